// File: rtl/sram_1r1w_be_if.sv
// Simple-dual-port SRAM bus: one write port and one read port with a read-valid strobe.
// The master drives requests and the slave (the memory) returns read data.
interface sram_1r1w_be_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 12
);
   logic                  wr_en;
   logic [DATA_W/8-1:0]   wr_be;
   logic [ADDR_W-1:0]     wr_addr;
   logic [DATA_W-1:0]     wr_data;
   logic                  rd_en;
   logic [ADDR_W-1:0]     rd_addr;
   logic [DATA_W-1:0]     rd_data;
   logic                  rd_valid;

   modport master (
      output wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
      input  rd_data, rd_valid
   );

   modport slave (
      input  wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
      output rd_data, rd_valid
   );
endinterface

// File: rtl/sram_1r1w_be.sv
// Simple-dual-port SRAM with per-byte write enables, configurable read-during-write policy
// and a post-reset clear engine that fills every word with INIT_VAL.
// Optional macro SRAM_OUT_REG_EN adds an output register stage (read latency 2 instead of 1).
module sram_1r1w_be #(
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       DEPTH    = 4096,
   parameter int unsigned       ADDR_W   = 12,
   parameter int unsigned       RDW_MODE = 0,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic          clk,
   input  logic          reset,
   output logic          init_busy,
   sram_1r1w_be_if.slave bus
);
   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [0:0] CLEAR = 1'b0;
   localparam logic [0:0] IDLE  = 1'b1;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [0:0]        state_q;
   logic [IDX_W-1:0]  clr_cnt_q;
   logic              busy;
   logic              clr_we;

   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;
   logic              wr_hit;
   logic              rd_hit;
   logic              rd_in_range;
   logic              rdw_hit;
   logic [DATA_W-1:0] wr_merged;
   logic [DATA_W-1:0] rd_word;

   logic [DATA_W-1:0] s1_data_q;
   logic              s1_valid_q;

   // Reset counts as busy so requests in the reset cycle itself are also ignored.
   assign busy      = reset || (state_q == CLEAR);
   assign init_busy = busy;
   assign clr_we    = !reset && (state_q == CLEAR);

   // Indices are truncated to the array width; the range checks keep them in bounds.
   assign wr_idx      = bus.wr_addr[IDX_W-1:0];
   assign rd_idx      = bus.rd_addr[IDX_W-1:0];
   assign rd_in_range = 32'(bus.rd_addr) < DEPTH;
   assign wr_hit      = bus.wr_en && !busy && (32'(bus.wr_addr) < DEPTH);
   assign rd_hit      = bus.rd_en && !busy;
   assign rdw_hit     = wr_hit && (bus.wr_addr == bus.rd_addr);

   // Clear FSM: walk the array once after reset release, then idle until the next reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
      end else if (state_q == CLEAR) begin
         if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
            state_q <= IDLE;
         end else begin
            clr_cnt_q <= clr_cnt_q + IDX_W'(1);
         end
      end
   end

   // Array write port: clear engine has the port while busy, then byte-lane user writes.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_cnt_q] <= INIT_VAL;
      end else if (wr_hit) begin
         for (int i = 0; i < int'(NB); i++) begin
            if (bus.wr_be[i]) mem[wr_idx][8*i +: 8] <= bus.wr_data[8*i +: 8];
         end
      end
   end

   // Post-write view of the written word, used for new-data read-during-write.
   always_comb begin
      wr_merged = mem[wr_idx];
      for (int i = 0; i < int'(NB); i++) begin
         if (bus.wr_be[i]) wr_merged[8*i +: 8] = bus.wr_data[8*i +: 8];
      end
   end

   // Read word selection: out-of-range reads return zero.
   always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
         if ((RDW_MODE == 1) && rdw_hit) rd_word = wr_merged;
         else                            rd_word = mem[rd_idx];
      end
   end

   // Array read register: data holds between reads, valid is a one-cycle strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_data_q  <= '0;
         s1_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= rd_hit;
         if (rd_hit) s1_data_q <= rd_word;
      end
   end

`ifdef SRAM_OUT_REG_EN
   logic [DATA_W-1:0] s2_data_q;
   logic              s2_valid_q;

   // Output register stage: only captures when valid data advances.
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_data_q  <= '0;
         s2_valid_q <= 1'b0;
      end else begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) s2_data_q <= s1_data_q;
      end
   end

   assign bus.rd_data  = s2_data_q;
   assign bus.rd_valid = s2_valid_q;
`else
   assign bus.rd_data  = s1_data_q;
   assign bus.rd_valid = s1_valid_q;
`endif
endmodule

// File: tb/tb_sram_1r1w_be.sv
// Self-checking bench for sram_1r1w_be: three instances (DEPTH 16 old-data, DEPTH 16 new-data,
// DEPTH 12 old-data) share one stimulus stream; a scoreboard checks every read result.
module tb_sram_1r1w_be;
`ifdef SRAM_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam logic [31:0] INIT = 32'hDEADBEEF;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      int          cyc;
   } exp_t;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        we    = 1'b0;
   logic [3:0]  be    = '0;
   logic [3:0]  wa    = '0;
   logic [31:0] wd    = '0;
   logic        re    = 1'b0;
   logic [3:0]  ra    = '0;
   logic        busy_a, busy_b, busy_c;

   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   live    = 1'b0;
   logic [31:0] m16 [16];
   logic [31:0] m12 [12];
   exp_t sb [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sram_1r1w_be_if #(.DATA_W(32), .ADDR_W(4)) bus_a ();
   sram_1r1w_be_if #(.DATA_W(32), .ADDR_W(4)) bus_b ();
   sram_1r1w_be_if #(.DATA_W(32), .ADDR_W(4)) bus_c ();

   assign bus_a.wr_en = we; assign bus_a.wr_be = be; assign bus_a.wr_addr = wa;
   assign bus_a.wr_data = wd; assign bus_a.rd_en = re; assign bus_a.rd_addr = ra;
   assign bus_b.wr_en = we; assign bus_b.wr_be = be; assign bus_b.wr_addr = wa;
   assign bus_b.wr_data = wd; assign bus_b.rd_en = re; assign bus_b.rd_addr = ra;
   assign bus_c.wr_en = we; assign bus_c.wr_be = be; assign bus_c.wr_addr = wa;
   assign bus_c.wr_data = wd; assign bus_c.rd_en = re; assign bus_c.rd_addr = ra;

   sram_1r1w_be #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .RDW_MODE(0), .INIT_VAL(INIT)) dut_a (
      .clk(clk), .reset(reset), .init_busy(busy_a), .bus(bus_a));
   sram_1r1w_be #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .RDW_MODE(1), .INIT_VAL(INIT)) dut_b (
      .clk(clk), .reset(reset), .init_busy(busy_b), .bus(bus_b));
   sram_1r1w_be #(.DATA_W(32), .DEPTH(12), .ADDR_W(4), .RDW_MODE(0), .INIT_VAL(INIT)) dut_c (
      .clk(clk), .reset(reset), .init_busy(busy_c), .bus(bus_c));

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   task automatic model_fill();
      for (int i = 0; i < 16; i++) m16[i] = INIT;
      for (int i = 0; i < 12; i++) m12[i] = INIT;
   endtask

   // One request cycle; the model is updated and expectations queued only once clear is done.
   task automatic drive(input logic w, input logic [3:0] wbe, input logic [3:0] waddr,
                        input logic [31:0] wdata, input logic r, input logic [3:0] raddr);
      exp_t e;
      @(posedge clk); #1;
      we = w; be = wbe; wa = waddr; wd = wdata; re = r; ra = raddr;
      if (live) begin
         if (r) begin
            e.a   = m16[raddr];
            e.b   = (w && waddr == raddr) ? merge(m16[raddr], wdata, wbe) : m16[raddr];
            e.c   = (raddr < 4'd12) ? m12[raddr] : 32'h0;
            e.cyc = cyc + LAT;
            sb.push_back(e);
         end
         if (w) begin
            m16[waddr] = merge(m16[waddr], wdata, wbe);
            if (waddr < 4'd12) m12[waddr] = merge(m12[waddr], wdata, wbe);
         end
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      we = 1'b0; be = '0; re = 1'b0;
   endtask

   // Lands on the negedge where a read issued just before the last idle() is visible.
   task automatic wait_result();
      repeat (LAT - 1) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus_a.rd_valid || bus_b.rd_valid || bus_c.rd_valid) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_rd_valid: valid abc=%b%b%b at cycle %0d, required none",
                        bus_a.rd_valid, bus_b.rd_valid, bus_c.rd_valid, cyc);
            end else begin
               e = sb.pop_front();
               if ({bus_a.rd_valid, bus_b.rd_valid, bus_c.rd_valid} !== 3'b111 ||
                   bus_a.rd_data !== e.a || bus_b.rd_data !== e.b || bus_c.rd_data !== e.c ||
                   cyc != e.cyc) begin
                  n_fail++;
                  $display("FAIL read_result: got valid=%b%b%b a=%h b=%h c=%h cyc=%0d, required valid=111 a=%h b=%h c=%h cyc=%0d",
                           bus_a.rd_valid, bus_b.rd_valid, bus_c.rd_valid, bus_a.rd_data,
                           bus_b.rd_data, bus_c.rd_data, cyc, e.a, e.b, e.c, e.cyc);
               end
            end
         end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_rd_valid: got none at cycle %0d, required a=%h at cycle %0d",
                     cyc, e.a, e.cyc);
         end
      end
   endtask

   // Counts busy cycles over a fixed window starting at reset release; zeroes requests at 10.
   task automatic count_busy(output int ca, output int cb, output int cc);
      ca = 0; cb = 0; cc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 10) begin we = 1'b0; re = 1'b0; be = '0; end
         ca += int'(busy_a); cb += int'(busy_b); cc += int'(busy_c);
      end
   endtask

   task automatic check_busy(input string name, input int ca, input int cb, input int cc);
      n_tests++;
      if (ca != 16 || cb != 16 || cc != 12) begin
         n_fail++;
         $display("FAIL %s: busy cycles a=%0d b=%0d c=%0d, required 16 16 12", name, ca, cb, cc);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      we = 1'b1; be = 4'hF; wa = 4'd3; wd = 32'hFFFF_FFFF; re = 1'b1; ra = 4'd3;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({busy_a, busy_b, busy_c} !== 3'b111 ||
          {bus_a.rd_valid, bus_b.rd_valid, bus_c.rd_valid} !== 3'b000 ||
          bus_a.rd_data !== 32'h0 || bus_b.rd_data !== 32'h0 || bus_c.rd_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b%b%b valid=%b%b%b data a=%h, required busy=111 valid=000 data=0",
                  busy_a, busy_b, busy_c, bus_a.rd_valid, bus_b.rd_valid, bus_c.rd_valid,
                  bus_a.rd_data);
      end
      we = 1'b0; re = 1'b0; be = '0;
   endtask

   task automatic test_clear();
      int ca, cb, cc;
      @(posedge clk); #1;
      reset = 1'b0;
      count_busy(ca, cb, cc);
      check_busy("clear_length", ca, cb, cc);
      model_fill();
      live = 1'b1;
      for (int i = 0; i < 16; i++) drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'(i));
      idle();
      wait_result();
      n_tests++;
      if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== INIT) begin
         n_fail++;
         $display("FAIL clear_last_word: got valid=%b data=%h, required 1 %h",
                  bus_a.rd_valid, bus_a.rd_data, INIT);
      end
   endtask

   task automatic test_byte_lanes();
      drive(1'b1, 4'hF, 4'd5, 32'h1122_3344, 1'b0, 4'd0);
      drive(1'b1, 4'b0101, 4'd5, 32'hAABB_CCDD, 1'b0, 4'd0);
      drive(1'b1, 4'b0000, 4'd5, 32'hFFFF_FFFF, 1'b0, 4'd0);
      drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd5);
      idle();
      wait_result();
      n_tests++;
      if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== 32'h11BB_33DD) begin
         n_fail++;
         $display("FAIL byte_lanes: got valid=%b data=%h, required 1 11bb33dd",
                  bus_a.rd_valid, bus_a.rd_data);
      end
   endtask

   task automatic test_rdw();
      drive(1'b1, 4'hF, 4'd7, 32'h0, 1'b0, 4'd0);
      drive(1'b1, 4'hF, 4'd7, 32'h1234_5678, 1'b1, 4'd7);
      idle();
      wait_result();
      n_tests++;
      if (bus_a.rd_data !== 32'h0 || bus_b.rd_data !== 32'h1234_5678 || bus_c.rd_data !== 32'h0) begin
         n_fail++;
         $display("FAIL rdw_same_cycle: got a=%h b=%h c=%h, required 00000000 12345678 00000000",
                  bus_a.rd_data, bus_b.rd_data, bus_c.rd_data);
      end
      drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd7);
      idle();
      wait_result();
      n_tests++;
      if (bus_a.rd_data !== 32'h1234_5678 || bus_b.rd_data !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL rdw_followup: got a=%h b=%h, required 12345678 12345678",
                  bus_a.rd_data, bus_b.rd_data);
      end
      drive(1'b1, 4'b0011, 4'd7, 32'hCAFE_F00D, 1'b1, 4'd7);
      idle();
      wait_result();
      n_tests++;
      if (bus_a.rd_data !== 32'h1234_5678 || bus_b.rd_data !== 32'h1234_F00D) begin
         n_fail++;
         $display("FAIL rdw_partial: got a=%h b=%h, required 12345678 1234f00d",
                  bus_a.rd_data, bus_b.rd_data);
      end
   endtask

   task automatic test_busy_gating();
      int ca, cb, cc;
      @(posedge clk); #1;
      live = 1'b0;
      reset = 1'b1;
      we = 1'b1; be = 4'hF; wa = 4'd2; wd = 32'hFFFF_FFFF; re = 1'b1; ra = 4'd2;
      repeat (2) @(posedge clk); #1;
      reset = 1'b0;
      // Counter reaches 9 after nine clear cycles; reset lands on the next edge.
      repeat (9) @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) @(posedge clk); #1;
      reset = 1'b0;
      count_busy(ca, cb, cc);
      check_busy("clear_restart", ca, cb, cc);
      model_fill();
      live = 1'b1;
      drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd2);
      idle();
      wait_result();
      n_tests++;
      if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== INIT || bus_c.rd_data !== INIT) begin
         n_fail++;
         $display("FAIL busy_write_ignored: got valid=%b a=%h c=%h, required 1 %h %h",
                  bus_a.rd_valid, bus_a.rd_data, bus_c.rd_data, INIT, INIT);
      end
   endtask

   task automatic test_out_of_range();
      drive(1'b1, 4'hF, 4'd13, 32'hA5A5_A5A5, 1'b0, 4'd0);
      drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd13);
      idle();
      wait_result();
      n_tests++;
      if (bus_c.rd_valid !== 1'b1 || bus_c.rd_data !== 32'h0 || bus_a.rd_data !== 32'hA5A5_A5A5) begin
         n_fail++;
         $display("FAIL out_of_range: got c valid=%b c=%h a=%h, required 1 00000000 a5a5a5a5",
                  bus_c.rd_valid, bus_c.rd_data, bus_a.rd_data);
      end
      for (int i = 0; i < 12; i++) drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'(i));
      idle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] v [3];
      logic [31:0] dat [8];
      logic [7:0]  vb;
      logic [7:0]  vb_exp;
      v[0] = 32'h0101_A0A0; v[1] = 32'h0202_B0B0; v[2] = 32'h0303_C0C0;
      for (int i = 0; i < 3; i++) drive(1'b1, 4'hF, 4'(i), v[i], 1'b0, 4'd0);
      fork
         begin
            for (int i = 0; i < 3; i++) drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'(i));
            idle();
         end
         begin
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               vb[i]  = bus_a.rd_valid;
               dat[i] = bus_a.rd_data;
            end
         end
      join
      vb_exp = 8'b0000_0111 << (1 + LAT);
      n_tests++;
      if (vb !== vb_exp) begin
         n_fail++;
         $display("FAIL stream_valid: got %b, required %b", vb, vb_exp);
      end
      for (int n = 0; n < 3; n++) begin
         n_tests++;
         if (dat[1 + LAT + n] !== v[n]) begin
            n_fail++;
            $display("FAIL stream_data%0d: got %h, required %h", n, dat[1 + LAT + n], v[n]);
         end
      end
      n_tests++;
      if (dat[7] !== v[2]) begin
         n_fail++;
         $display("FAIL stream_hold: got %h, required %h", dat[7], v[2]);
      end
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_clear();
      test_byte_lanes();
      test_rdw();
      test_busy_gating();
      test_out_of_range();
      test_back_to_back();
      repeat (LAT + 3) @(posedge clk);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending reads, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sram_1r1w_be.md
Name: sram_1r1w_be

Overview:
Parametrised successor to the team's single-port 32-bit SRAM model. It is a simple-dual-port memory with one write port and one read port, and it is used for rtlsim and FPGA-facing memories. Width, depth, per-byte write enables and read-during-write policy are all configurable. A built-in clear engine fills the whole array with a known value after reset, and a read-valid strobe accompanies every read result.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8.
DEPTH, 4096, number of words; need not be a power of 2.
ADDR_W, 12, address width; must satisfy 2^ADDR_W >= DEPTH.
RDW_MODE, 0, same-address read-during-write policy: 0 = old data returned, 1 = new (merged) data returned.
INIT_VAL, 0, DATA_W-bit value written to every word by the clear engine.

Ports:
clk  input  1  single clock; all logic is on its rising edge.
reset  input  1  synchronous reset, active-high.
init_busy  output  1  high while reset is held or the clear engine is running.
wr_en  input  1  write request.
wr_be  input  DATA_W/8  byte-lane write enables; bit i covers data bits [8i+7:8i].
wr_addr  input  ADDR_W  write word address.
wr_data  input  DATA_W  write data.
rd_en  input  1  read request.
rd_addr  input  ADDR_W  read word address.
rd_data  output  DATA_W  read data; holds its value between reads.
rd_valid  output  1  one-cycle strobe; rd_data is new this cycle.

Behaviour:
- Reset values: init_busy=1, rd_valid=0, rd_data=0, clear FSM in state CLEAR, clear counter=0.
- Clear FSM:
  - While reset is high, it stays in CLEAR with counter=0 and performs no writes.
  - After reset is released, each cycle writes INIT_VAL to mem[counter] and increments counter.
  - When counter==DEPTH-1 is written, the FSM moves to IDLE and init_busy drops on the next cycle. The clear therefore takes exactly DEPTH cycles after reset deassertion.
  - IDLE is terminal until the next reset.
  - Reset asserted mid-clear restarts the sequence at address 0. Memory contents are otherwise not cleared by reset.
- While init_busy=1:
  - wr_en and rd_en are ignored.
  - rd_valid stays 0 and rd_data holds 0.
- Write, when not busy:
  - With wr_en=1, mem[wr_addr] byte lane i takes wr_data lane i for every wr_be[i]=1; the other lanes keep their value.
  - wr_en=1 with wr_be=0 is a no-op.
  - wr_addr >= DEPTH: the write is dropped.
- Read, when not busy:
  - Latency is 1. rd_en=1 in cycle N gives rd_data updated and rd_valid=1 in cycle N+1.
  - rd_en=0 in cycle N gives rd_valid=0 in N+1, and rd_data keeps its previous value.
  - rd_addr >= DEPTH: rd_data=0 with rd_valid=1.
- Read and write to the same address in the same cycle:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the post-write merged word, i.e. written lanes new and unwritten lanes old.
  - Different addresses: the two ports are independent.
- Back-to-back reads every cycle are supported, giving full throughput.

Optional Feature:
SRAM_OUT_REG_EN
- Defined: an extra output register stage follows the array read.
  - Read latency becomes 2 cycles. rd_valid is delayed identically, and the stage holds its value when no valid data advances.
  - Reset clears the stage to data 0 and valid 0.
  - RDW semantics are evaluated at the array access cycle, not at the output.
- Undefined: latency is 1 cycle, exactly as above.

Test Plan:
1. Clear: DEPTH=16, INIT_VAL=32'hDEADBEEF, reset high for 3 cycles then low -> init_busy stays high 16 cycles after deassertion and then drops; reads of addresses 0..15 all return 32'hDEADBEEF with rd_valid=1 one cycle after each rd_en.
2. Byte lanes: write 32'h11223344 with be=4'hF to addr 5, then 32'hAABBCCDD with be=4'b0101 to addr 5, then read addr 5 -> 32'h11BB33DD.
3. Read-during-write: mem[7]=32'h0 initially; same cycle, write 32'h12345678 be=F and read addr 7 -> RDW_MODE=0 returns 32'h0, RDW_MODE=1 returns 32'h12345678; a following read returns 32'h12345678 in both modes.
4. Busy gating and reset mid-clear: issue wr_en to addr 2 with 32'hFFFFFFFF and rd_en during the clear, and assert reset at counter=9 -> no rd_valid during busy; the clear restarts and completes 16 cycles after the second reset release; addr 2 reads INIT_VAL.
5. Out-of-range: DEPTH=12, ADDR_W=4; write addr 13 then read addr 13 -> rd_data=0, rd_valid=1; addr 0..11 are unchanged.
6. Streaming with SRAM_OUT_REG_EN defined and undefined: reads to addrs 0,1,2 on consecutive cycles -> rd_valid high for 3 consecutive cycles starting at N+1 (undefined) or N+2 (defined), with data in order; rd_data holds the addr-2 value afterwards.
